// File: rtl/cmp_issuer.sv
// Comparator initiator: registers one compare command at a time, drives the
// combinational comparator, and returns the tagged result with hit/total counts.

package comparator_pkg;
    typedef enum logic [2:0] {
        inf       = 3'd0,
        sup       = 3'd1,
        inf_or_eq = 3'd2,
        sup_or_eq = 3'd3,
        eq        = 3'd4,
        neq       = 3'd5
    } comparator_intr_e;
endpackage

// state  | meaning
// idle   | ready for a command; cmp_* hold the last issued command
// issue  | registered command on cmp_*; result sampled at the closing edge
// resp   | response valid, held stable until rsp_ready_i
module cmp_issuer
    import comparator_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int IdWidth   = 4,
    parameter int CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  comparator_intr_e     req_instr_i,
    input  logic [DataWidth-1:0] req_a_i,
    input  logic [DataWidth-1:0] req_b_i,
    input  logic [DataWidth-1:0] req_prec_i,
    input  logic [IdWidth-1:0]   req_id_i,
    output comparator_intr_e     cmp_instr_o,
    output logic [DataWidth-1:0] cmp_a_o,
    output logic [DataWidth-1:0] cmp_b_o,
    output logic [DataWidth-1:0] cmp_prec_o,
    input  logic                 cmp_result_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_result_o,
    output logic                 rsp_err_o,
    output logic                 rsp_wrap_o,
    output logic [IdWidth-1:0]   rsp_id_o,
    input  logic                 clear_i,
    output logic [CntWidth-1:0]  hit_count_o,
    output logic [CntWidth-1:0]  total_count_o
);

    typedef enum logic [1:0] {
        st_idle  = 2'd0,
        st_issue = 2'd1,
        st_resp  = 2'd2
    } state_e;

    state_e               state;
    logic [IdWidth-1:0]   id_q;
    logic                 instr_ok;
    logic                 is_window;
    logic                 window_wrap;
    logic [DataWidth:0]   lo_diff;
    logic [DataWidth:0]   hi_sum;
    logic                 rsp_fire;

    // Extra top bit catches both b-prec underflow and b+prec overflow.
    always_comb begin
        instr_ok  = 1'b0;
        is_window = 1'b0;
        case (cmp_instr_o)
            inf, sup, inf_or_eq, sup_or_eq: instr_ok = 1'b1;
            eq, neq: begin
                instr_ok  = 1'b1;
                is_window = 1'b1;
            end
            default: instr_ok = 1'b0;
        endcase
        lo_diff     = {1'b0, cmp_b_o} - {1'b0, cmp_prec_o};
        hi_sum      = {1'b0, cmp_b_o} + {1'b0, cmp_prec_o};
        window_wrap = is_window && (cmp_prec_o != '0) &&
                      (lo_diff[DataWidth] || hi_sum[DataWidth]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= st_idle;
            req_ready_o  <= 1'b1;
            cmp_instr_o  <= inf;
            cmp_a_o      <= '0;
            cmp_b_o      <= '0;
            cmp_prec_o   <= '0;
            id_q         <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_result_o <= 1'b0;
            rsp_err_o    <= 1'b0;
            rsp_wrap_o   <= 1'b0;
            rsp_id_o     <= '0;
        end else begin
            case (state)
                st_idle: begin
                    if (req_valid_i) begin
                        cmp_instr_o <= req_instr_i;
                        cmp_a_o     <= req_a_i;
                        cmp_b_o     <= req_b_i;
                        cmp_prec_o  <= req_prec_i;
                        id_q        <= req_id_i;
                        req_ready_o <= 1'b0;
                        state       <= st_issue;
                    end
                end
                st_issue: begin
                    rsp_result_o <= instr_ok & cmp_result_i;
                    rsp_err_o    <= ~instr_ok;
                    rsp_wrap_o   <= window_wrap;
                    rsp_id_o     <= id_q;
                    rsp_valid_o  <= 1'b1;
                    state        <= st_resp;
                end
                st_resp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= st_idle;
                    end
                end
                default: begin
                    rsp_valid_o <= 1'b0;
                    req_ready_o <= 1'b1;
                    state       <= st_idle;
                end
            endcase
        end
    end

    assign rsp_fire = rsp_valid_o && rsp_ready_i;

    // Clear takes priority over a coincident handshake; counts saturate.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_count_o   <= '0;
            total_count_o <= '0;
        end else if (clear_i) begin
            hit_count_o   <= '0;
            total_count_o <= '0;
        end else if (rsp_fire) begin
            if (total_count_o != '1)
                total_count_o <= total_count_o + CntWidth'(1);
            if (rsp_result_o && !rsp_err_o && (hit_count_o != '1))
                hit_count_o <= hit_count_o + CntWidth'(1);
        end
    end

endmodule
